// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding constants, encoder state type and a byte-layout helper.
// Any stage that needs to build or pick apart the instruction byte stream can reuse these.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_NONE   = 4'hF;

  typedef enum logic [1:0] {StIdle, StEmit, StErr} enc_state_e;

  // Byte idx of an encoded instruction; valC starts right after the register byte, if any.
  function automatic logic [7:0] enc_byte(input logic [3:0]  icode,
                                          input logic [3:0]  ifun,
                                          input logic [3:0]  ra,
                                          input logic [3:0]  rb,
                                          input logic [63:0] valc,
                                          input logic        has_regs,
                                          input logic        has_valc,
                                          input logic [3:0]  idx);
    logic [3:0]  off;
    logic [63:0] sh;
    if (idx == 4'd0) return {icode, ifun};
    if (has_regs && idx == 4'd1) return {(icode == I_IRMOVQ) ? R_NONE : ra, rb};
    if (!has_valc) return 8'h00;
    off = has_regs ? 4'd2 : 4'd1;
    sh  = valc >> {idx - off, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational Y86-64 instruction classifier: length, register byte, constant word and
// icode/ifun legality. Fetch reuses it to compute valP.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  input  logic [3:0] ifun_i,
  output logic [3:0] len_o,
  output logic       has_regs_o,
  output logic       has_valc_o,
  output logic       legal_o
);

  always_comb begin
    len_o      = 4'd1;
    has_regs_o = 1'b0;
    has_valc_o = 1'b0;
    legal_o    = (ifun_i == 4'd0);
    case (icode_i)
      I_HALT, I_NOP, I_RET: ;
      I_RRMOVQ: begin
        len_o      = 4'd2;
        has_regs_o = 1'b1;
        legal_o    = (ifun_i <= 4'd6);
      end
      I_OPQ: begin
        len_o      = 4'd2;
        has_regs_o = 1'b1;
        legal_o    = (ifun_i <= 4'd3);
      end
      I_PUSHQ, I_POPQ: begin
        len_o      = 4'd2;
        has_regs_o = 1'b1;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        len_o      = 4'd10;
        has_regs_o = 1'b1;
        has_valc_o = 1'b1;
      end
      I_JXX: begin
        len_o      = 4'd9;
        has_valc_o = 1'b1;
        legal_o    = (ifun_i <= 4'd6);
      end
      I_CALL: begin
        len_o      = 4'd9;
        has_valc_o = 1'b1;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_instr_encoder.sv
// Y86-64 instruction encoder: accepts one decoded instruction per handshake, checks it and
// writes its bytes into instruction memory one per cycle at the internal write pointer.
module y86_instr_encoder
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_addr,
  input  logic [ADDR_W-1:0] new_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              done,
  output logic              enc_error,
  output logic [3:0]        instr_len
);

  enc_state_e        state_q;
  logic [3:0]        icode_q, ifun_q, ra_q, rb_q, len_q, idx_q, instr_len_q;
  logic [63:0]       valc_q;
  logic              has_regs_q, has_valc_q;
  logic [ADDR_W-1:0] wr_ptr_q, mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              mem_we_q, done_q, enc_error_q;

  logic [3:0]        in_len;
  logic              in_has_regs, in_has_valc, in_legal;
  logic [ADDR_W:0]   end_addr;
  logic              fits;
  logic [7:0]        cur_byte;

  y86_instr_len u_len (
    .icode_i    (icode),
    .ifun_i     (ifun),
    .len_o      (in_len),
    .has_regs_o (in_has_regs),
    .has_valc_o (in_has_valc),
    .legal_o    (in_legal)
  );

  // One extra bit so a pointer near the top of the address space cannot wrap into range.
  assign end_addr = {1'b0, wr_ptr_q} + (ADDR_W+1)'(in_len);
  assign fits     = (end_addr <= (ADDR_W+1)'(MEM_BYTES));
  assign cur_byte = enc_byte(icode_q, ifun_q, ra_q, rb_q, valc_q, has_regs_q, has_valc_q, idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      icode_q     <= 4'd0;
      ifun_q      <= 4'd0;
      ra_q        <= 4'd0;
      rb_q        <= 4'd0;
      valc_q      <= 64'd0;
      len_q       <= 4'd0;
      has_regs_q  <= 1'b0;
      has_valc_q  <= 1'b0;
      idx_q       <= 4'd0;
      wr_ptr_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      done_q      <= 1'b0;
      enc_error_q <= 1'b0;
      instr_len_q <= 4'd0;
    end else begin
      done_q      <= 1'b0;
      enc_error_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (set_addr) begin
            wr_ptr_q <= new_addr;
          end else if (in_valid) begin
            icode_q    <= icode;
            ifun_q     <= ifun;
            ra_q       <= rA;
            rb_q       <= rB;
            valc_q     <= valC;
            len_q      <= in_len;
            has_regs_q <= in_has_regs;
            has_valc_q <= in_has_valc;
            if (in_legal && fits) begin
              // Byte 0 goes out in the very next cycle.
              state_q     <= StEmit;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= wr_ptr_q;
              mem_wdata_q <= {icode, ifun};
              idx_q       <= 4'd1;
            end else begin
              state_q     <= StErr;
              enc_error_q <= 1'b1;
            end
          end
        end
        StEmit: begin
          if (idx_q == len_q) begin
            state_q     <= StIdle;
            mem_we_q    <= 1'b0;
            wr_ptr_q    <= wr_ptr_q + ADDR_W'(len_q);
            instr_len_q <= len_q;
            done_q      <= 1'b1;
          end else begin
            mem_addr_q  <= wr_ptr_q + ADDR_W'(idx_q);
            mem_wdata_q <= cur_byte;
            idx_q       <= idx_q + 4'd1;
          end
        end
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wr_ptr    = wr_ptr_q;
  assign done      = done_q;
  assign enc_error = enc_error_q;
  assign instr_len = instr_len_q;

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Bench for y86_instr_encoder: a transaction-level model predicts every output cycle by cycle;
// directed programs, boundary cases and random instructions are checked against it.
module tb_y86_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_addr = 1'b0;
  logic [63:0] new_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  icode = '0, ifun = '0, rA = '0, rB = '0;
  logic [63:0] valC = '0;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [63:0] wr_ptr;
  logic        done, enc_error;
  logic [3:0]  instr_len;

  y86_instr_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .set_addr  (set_addr),
    .new_addr  (new_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .icode     (icode),
    .ifun      (ifun),
    .rA        (rA),
    .rB        (rB),
    .valC      (valC),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .wr_ptr    (wr_ptr),
    .done      (done),
    .enc_error (enc_error),
    .instr_len (instr_len)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  data;
    logic        done;
    logic        err;
    logic        ready;
    logic [63:0] wrptr;
    logic [3:0]  ilen;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  dut_mem [logic [63:0]];

  // Model state, per instruction rather than per cycle.
  logic [63:0] m_wrptr = '0, m_addr = '0;
  logic [7:0]  m_data = '0;
  logic [3:0]  m_ilen = '0;

  int lens   [12] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2};
  int maxfun [12] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0};

  function automatic bit has_reg_byte(input logic [3:0] ic);
    return ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
  endfunction

  function automatic logic [79:0] model_bytes(input logic [3:0] ic, ifn, ra, rb,
                                              input logic [63:0] vc);
    logic [79:0] b;
    int pos;
    b = '0;
    b[7:0] = {ic, ifn};
    pos = 1;
    if (has_reg_byte(ic)) begin
      b[15:8] = {(ic == 4'h3) ? 4'hF : ra, rb};
      pos = 2;
    end
    if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8})
      for (int k = 0; k < 8; k++) b[8*(pos+k) +: 8] = vc[8*k +: 8];
    return b;
  endfunction

  function automatic exp_t idle_e();
    exp_t e;
    e = '{we: 1'b0, addr: m_addr, data: m_data, done: 1'b0, err: 1'b0, ready: 1'b1,
          wrptr: m_wrptr, ilen: m_ilen};
    return e;
  endfunction

  function automatic exp_t reset_e();
    exp_t e;
    e = '{we: 1'b0, addr: '0, data: '0, done: 1'b0, err: 1'b0, ready: 1'b1, wrptr: '0,
          ilen: '0};
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e, a;
    if (mem_we) dut_mem[mem_addr] = mem_wdata;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{we: mem_we, addr: mem_addr, data: mem_wdata, done: done, err: enc_error,
            ready: in_ready, wrptr: wr_ptr, ilen: instr_len};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle_out t=%0t: got we=%b addr=%0h data=%0h done=%b err=%b rdy=%b wp=%0h len=%0d; want we=%b addr=%0h data=%0h done=%b err=%b rdy=%b wp=%0h len=%0d",
                 $time, a.we, a.addr, a.data, a.done, a.err, a.ready, a.wrptr, a.ilen,
                 e.we, e.addr, e.data, e.done, e.err, e.ready, e.wrptr, e.ilen);
      end
    end
  end

  task automatic tick(input exp_t e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic clear_in();
    in_valid = 1'b0;
    set_addr = 1'b0;
  endtask

  // Noise on inputs the DUT must ignore while busy.
  task automatic garbage();
    in_valid = 1'($urandom);
    set_addr = 1'($urandom);
    new_addr = {$urandom, $urandom};
    icode = 4'($urandom);
    ifun = 4'($urandom);
    rA = 4'($urandom);
    rB = 4'($urandom);
    valC = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    tick(reset_e());
    m_wrptr = '0;
    m_addr = '0;
    m_data = '0;
    m_ilen = '0;
    rst = 1'b0;
  endtask

  task automatic set_ptr(input logic [63:0] a);
    set_addr = 1'b1;
    new_addr = a;
    in_valid = 1'b1;
    icode = 4'h1;
    ifun = 4'h0;
    m_wrptr = a;
    tick(idle_e());
    clear_in();
  endtask

  task automatic send(input logic [3:0] ic, ifn, ra, rb, input logic [63:0] vc,
                      input int abort_at);
    int          len;
    bit          legal;
    logic [79:0] b;
    logic [64:0] end_a;
    exp_t        e;
    set_addr = 1'b0;
    in_valid = 1'b1;
    icode = ic;
    ifun = ifn;
    rA = ra;
    rB = rb;
    valC = vc;
    len = (ic <= 4'hB) ? lens[ic] : 1;
    end_a = {1'b0, m_wrptr} + 65'(len);
    legal = (ic <= 4'hB) && (int'(ifn) <= maxfun[ic]) && (end_a <= 65'd1024);
    if (legal) begin
      b = model_bytes(ic, ifn, ra, rb, vc);
      for (int j = 0; j < len; j++) begin
        e = idle_e();
        e.we = 1'b1;
        e.addr = m_wrptr + 64'(j);
        e.data = b[8*j +: 8];
        e.ready = 1'b0;
        m_addr = e.addr;
        m_data = e.data;
        tick(e);
        garbage();
        if (j == abort_at) begin
          rst = 1'b1;
          tick(reset_e());
          m_wrptr = '0;
          m_addr = '0;
          m_data = '0;
          m_ilen = '0;
          rst = 1'b0;
          clear_in();
          return;
        end
      end
      m_wrptr = m_wrptr + 64'(len);
      m_ilen = 4'(len);
      e = idle_e();
      e.done = 1'b1;
      tick(e);
      clear_in();
    end else begin
      e = idle_e();
      e.err = 1'b1;
      e.ready = 1'b0;
      tick(e);
      garbage();
      tick(idle_e());
      clear_in();
    end
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic lit_mem(input string name, input logic [63:0] base, input logic [79:0] want,
                         input int n);
    for (int i = 0; i < n; i++)
      lit(name, dut_mem.exists(base + 64'(i)) ? 64'(dut_mem[base + 64'(i)]) : 64'hBAD,
          64'(want[8*(n-1-i) +: 8]));
  endtask

  initial begin
    int r;
    do_reset();
    tick(idle_e());

    // Small program from address 0, back to back.
    send(4'h3, 4'h0, 4'h0, 4'h0, 64'h100, -1);
    lit("irmovq_wr_ptr", wr_ptr, 64'd10);
    lit("irmovq_len", 64'(instr_len), 64'd10);
    send(4'h2, 4'h0, 4'h0, 4'h3, 64'h0, -1);
    send(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, -1);
    send(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, -1);
    lit("prog_wr_ptr", wr_ptr, 64'd14);
    lit_mem("prog_bytes", 64'd0, 80'h30F0_0001_0000_0000_0000, 10);
    lit_mem("prog_tail", 64'd10, 80'h2003_1000, 4);

    set_ptr(64'h40);
    send(4'h8, 4'h0, 4'hF, 4'hF, 64'h0123_4567_89AB_CDEF, -1);
    lit("call_wr_ptr", wr_ptr, 64'h49);
    lit_mem("call_bytes", 64'h40, 80'h80EF_CDAB_8967_4523_01, 9);

    send(4'hC, 4'h0, 4'h0, 4'h0, 64'h0, -1);
    send(4'h6, 4'h4, 4'h1, 4'h2, 64'h0, -1);
    send(4'hA, 4'h1, 4'h3, 4'hF, 64'h0, -1);
    lit("illegal_wr_ptr", wr_ptr, 64'h49);

    set_ptr(64'd1015);
    send(4'h3, 4'h0, 4'h0, 4'h1, 64'h55, -1);
    set_ptr(64'd1014);
    send(4'h3, 4'h0, 4'h0, 4'h1, 64'h55, -1);
    lit("top_fit_wr_ptr", wr_ptr, 64'd1024);
    set_ptr(64'hFFFF_FFFF_FFFF_FFFE);
    send(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, -1);
    send(4'h2, 4'h0, 4'h1, 4'h2, 64'h0, -1);
    lit("wrap_wr_ptr", wr_ptr, 64'hFFFF_FFFF_FFFF_FFFE);

    set_ptr(64'd100);
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h1122_3344_5566_7788, 3);
    tick(idle_e());
    lit("abort_wr_ptr", wr_ptr, 64'd0);

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8 || (m_wrptr > 64'd1010 && r < 40)) begin
        set_ptr(64'($urandom_range(0, 1030)));
      end else if (r < 10) begin
        set_ptr(64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15)));
      end else if (r < 15) begin
        tick(idle_e());
      end else begin
        logic [3:0] ic, fn;
        ic = ($urandom_range(0, 99) < 90) ? 4'($urandom_range(0, 11)) : 4'($urandom);
        if (ic <= 4'hB && $urandom_range(0, 99) < 75)
          fn = 4'($urandom_range(0, maxfun[ic]));
        else
          fn = 4'($urandom);
        send(ic, fn, 4'($urandom), 4'($urandom), {$urandom, $urandom},
             ($urandom_range(0, 99) < 2) ? int'($urandom_range(0, 1)) : -1);
      end
    end

    tick(idle_e());
    @(negedge clk);
    #1;
    lit("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
